// File: rtl/dma_write_engine.sv
// AXI3 S2MM write engine: drains 32-bit FIFO words, packs them into 64-bit beats and bursts them to DDR over HP0.
// Bursts start only once the FIFO holds the whole burst and never cross a 4 KB page.
module dma_write_engine #(
    parameter logic [5:0] AXI_ID    = 6'h1,
    parameter int         MAX_BURST = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dma_enable_i,
    input  logic [31:0] dma_base_addr_i,
    input  logic [15:0] dma_word_len_i,
    input  logic        dma_start_i,
    output logic        dma_busy_o,
    output logic        dma_done_o,
    output logic        dma_err_o,
    output logic        fifo_rd_en_o,
    input  logic [31:0] fifo_rd_out_i,
    input  logic [8:0]  fifo_rd_count_i,
    output logic [31:0] S_AXI_HP0_awaddr,
    output logic [3:0]  S_AXI_HP0_awlen,
    output logic [2:0]  S_AXI_HP0_awsize,
    output logic [1:0]  S_AXI_HP0_awburst,
    output logic [3:0]  S_AXI_HP0_awcache,
    output logic [5:0]  S_AXI_HP0_awid,
    output logic        S_AXI_HP0_awvalid,
    input  logic        S_AXI_HP0_awready,
    output logic [5:0]  S_AXI_HP0_wid,
    output logic [63:0] S_AXI_HP0_wdata,
    output logic [7:0]  S_AXI_HP0_wstrb,
    output logic        S_AXI_HP0_wlast,
    output logic        S_AXI_HP0_wvalid,
    input  logic        S_AXI_HP0_wready,
    input  logic [1:0]  S_AXI_HP0_bresp,
    input  logic        S_AXI_HP0_bvalid,
    output logic        S_AXI_HP0_bready,
    output logic [7:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ADDR  = 3'd2,
        S_FETCH = 3'd3,
        S_DATA  = 3'd4,
        S_RESP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic        start_q;
    logic [31:0] addr;
    logic [15:0] beats_left;
    logic        odd;
    logic [4:0]  blen;
    logic [4:0]  beat_idx;
    logic        last_odd;
    logic [1:0]  fph;
    logic        pop_q, pop_hi_q;
    logic [31:0] beat_lo, beat_hi;
    logic        err;

    logic        start_edge;
    logic [9:0]  page_room;
    logic [4:0]  blen_calc;
    logic        calc_last;
    logic [5:0]  words_need;
    logic [4:0]  blen_m1;
    logic        half_beat;
    logic        unused_base_bits;

    assign start_edge       = dma_start_i & ~start_q;
    assign page_room        = 10'd512 - {1'b0, addr[11:3]};
    assign calc_last        = (beats_left == {11'd0, blen_calc});
    assign words_need       = {blen_calc, 1'b0} - {5'd0, calc_last & odd};
    assign blen_m1          = blen - 5'd1;
    assign half_beat        = last_odd && (beat_idx == blen_m1);
    assign unused_base_bits = ^dma_base_addr_i[2:0];

    always_comb begin
        blen_calc = 5'(MAX_BURST);
        if (beats_left < 16'(MAX_BURST))
            blen_calc = beats_left[4:0];
        if ({6'd0, page_room} < {11'd0, blen_calc})
            blen_calc = page_room[4:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // fph sequences the two pops of a beat: 0 = pop lo, 1 = pop hi, 2 = hi lands in the beat register
    always_comb begin
        state_nxt    = state;
        fifo_rd_en_o = 1'b0;
        case (state)
            S_IDLE:  if (start_edge && dma_enable_i)
                         state_nxt = (dma_word_len_i == 16'd0) ? S_DONE : S_WAIT;
            S_WAIT:  if (!dma_enable_i)
                         state_nxt = S_DONE;
                     else if (fifo_rd_count_i >= {3'd0, words_need})
                         state_nxt = S_ADDR;
            S_ADDR:  if (S_AXI_HP0_awready) state_nxt = S_FETCH;
            S_FETCH: case (fph)
                         2'd0: fifo_rd_en_o = (fifo_rd_count_i != 9'd0);
                         2'd1: if (half_beat) state_nxt = S_DATA;
                               else fifo_rd_en_o = (fifo_rd_count_i != 9'd0);
                         default: state_nxt = S_DATA;
                     endcase
            S_DATA:  if (S_AXI_HP0_wready)
                         state_nxt = (beat_idx == blen_m1) ? S_RESP : S_FETCH;
            S_RESP:  if (S_AXI_HP0_bvalid) begin
                         if (S_AXI_HP0_bresp != 2'b00 || beats_left == {11'd0, blen})
                             state_nxt = S_DONE;
                         else
                             state_nxt = S_WAIT;
                     end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q    <= 1'b0;
            addr       <= '0;
            beats_left <= '0;
            odd        <= 1'b0;
            blen       <= '0;
            beat_idx   <= '0;
            last_odd   <= 1'b0;
            fph        <= '0;
            pop_q      <= 1'b0;
            pop_hi_q   <= 1'b0;
            beat_lo    <= '0;
            beat_hi    <= '0;
            err        <= 1'b0;
        end else begin
            start_q  <= dma_start_i;
            pop_q    <= fifo_rd_en_o;
            pop_hi_q <= (fph == 2'd1);
            if (state_nxt != S_FETCH)
                fph <= 2'd0;
            else if (fifo_rd_en_o)
                fph <= fph + 2'd1;
            // hi half reads as zero unless a hi word is popped for this beat
            if (fifo_rd_en_o && fph == 2'd0)
                beat_hi <= '0;
            if (pop_q) begin
                if (pop_hi_q) beat_hi <= fifo_rd_out_i;
                else          beat_lo <= fifo_rd_out_i;
            end
            case (state)
                S_IDLE: if (start_edge && dma_enable_i) begin
                    addr       <= {dma_base_addr_i[31:3], 3'b000};
                    beats_left <= 16'(({1'b0, dma_word_len_i} + 17'd1) >> 1);
                    odd        <= dma_word_len_i[0];
                    err        <= 1'b0;
                end
                S_WAIT: if (state_nxt == S_ADDR) begin
                    blen     <= blen_calc;
                    last_odd <= calc_last & odd;
                end
                S_ADDR: beat_idx <= '0;
                S_DATA: if (S_AXI_HP0_wready && beat_idx != blen_m1)
                    beat_idx <= beat_idx + 5'd1;
                S_RESP: if (S_AXI_HP0_bvalid) begin
                    addr       <= addr + {24'd0, blen, 3'd0};
                    beats_left <= beats_left - {11'd0, blen};
                    if (S_AXI_HP0_bresp != 2'b00)
                        err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dma_busy_o        = (state != S_IDLE) && (state != S_DONE);
    assign dma_done_o        = (state == S_DONE);
    assign dma_err_o         = err;

    assign S_AXI_HP0_awvalid = (state == S_ADDR);
    assign S_AXI_HP0_awaddr  = S_AXI_HP0_awvalid ? addr : 32'd0;
    assign S_AXI_HP0_awlen   = S_AXI_HP0_awvalid ? blen_m1[3:0] : 4'd0;
    assign S_AXI_HP0_awsize  = 3'b011;
    assign S_AXI_HP0_awburst = 2'b01;
    assign S_AXI_HP0_awcache = 4'b0011;
    assign S_AXI_HP0_awid    = AXI_ID;

    assign S_AXI_HP0_wid     = AXI_ID;
    assign S_AXI_HP0_wvalid  = (state == S_DATA);
    assign S_AXI_HP0_wdata   = S_AXI_HP0_wvalid ? {beat_hi, beat_lo} : 64'd0;
    assign S_AXI_HP0_wstrb   = !S_AXI_HP0_wvalid ? 8'h00 : (half_beat ? 8'h0F : 8'hFF);
    assign S_AXI_HP0_wlast   = S_AXI_HP0_wvalid && (beat_idx == blen_m1);
    assign S_AXI_HP0_bready  = (state == S_RESP);

    assign dbg_state_o       = {err, dma_busy_o, 3'b000, state};

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: a FIFO/HP0-slave agent plus a burst-list reference model built from the job parameters.
module tb_dma_write_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_enable, dma_start;
    logic [31:0] dma_base_addr;
    logic [15:0] dma_word_len;
    logic        dma_busy, dma_done, dma_err;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_out;
    logic [8:0]  fifo_rd_count;
    logic [31:0] awaddr;
    logic [3:0]  awlen, awcache;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [5:0]  awid, wid;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [63:0] wdata;
    logic [7:0]  wstrb, dbg_state;

    always #5 clk = ~clk;

    dma_write_engine dut (
        .clk_i(clk), .rst_i(rst), .dma_enable_i(dma_enable),
        .dma_base_addr_i(dma_base_addr), .dma_word_len_i(dma_word_len), .dma_start_i(dma_start),
        .dma_busy_o(dma_busy), .dma_done_o(dma_done), .dma_err_o(dma_err),
        .fifo_rd_en_o(fifo_rd_en), .fifo_rd_out_i(fifo_rd_out), .fifo_rd_count_i(fifo_rd_count),
        .S_AXI_HP0_awaddr(awaddr), .S_AXI_HP0_awlen(awlen), .S_AXI_HP0_awsize(awsize),
        .S_AXI_HP0_awburst(awburst), .S_AXI_HP0_awcache(awcache), .S_AXI_HP0_awid(awid),
        .S_AXI_HP0_awvalid(awvalid), .S_AXI_HP0_awready(awready), .S_AXI_HP0_wid(wid),
        .S_AXI_HP0_wdata(wdata), .S_AXI_HP0_wstrb(wstrb), .S_AXI_HP0_wlast(wlast),
        .S_AXI_HP0_wvalid(wvalid), .S_AXI_HP0_wready(wready), .S_AXI_HP0_bresp(bresp),
        .S_AXI_HP0_bvalid(bvalid), .S_AXI_HP0_bready(bready), .dbg_state_o(dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] fq[$];
    logic [31:0] src[$];
    logic [35:0] exp_aw[$];
    logic [72:0] exp_w[$];
    int n_exp_aw, n_exp_w;
    int trickle, ready_pct, stall_len, err_burst;
    int pops, aw_cnt, w_cnt, wl_cnt, b_pending, b_idx, b_wait, aw_hold, w_hold;
    bit pop_pend, b_hs, aw_pend, w_pend;
    logic [36:0] aw_prev;
    logic [73:0] w_prev;

    task automatic monitor_step();
        if (rst) begin
            aw_pend  = 0;
            w_pend   = 0;
            pop_pend = 0;
            b_hs     = 0;
            return;
        end
        if (aw_pend) check("aw_stable", 128'({awvalid, awaddr, awlen}), 128'(aw_prev));
        if (w_pend)  check("w_stable", 128'({wvalid, wlast, wstrb, wdata}), 128'(w_prev));
        if (fifo_rd_en) check("pop_when_empty", 128'(fifo_rd_count), 128'(fq.size()));
        if (wvalid && wready) begin
            check("w_after_aw", 128'(aw_cnt > wl_cnt), 128'd1);
            if (exp_w.size() > 0)
                check("wbeat", 128'({wlast, wstrb, wdata}), 128'(exp_w.pop_front()));
            w_cnt++;
            w_hold = 0;
            if (wlast) begin
                wl_cnt++;
                b_pending++;
            end
        end
        if (awvalid && awready) begin
            if (exp_aw.size() > 0)
                check("aw", 128'({awaddr, awlen}), 128'(exp_aw.pop_front()));
            aw_cnt++;
            aw_hold = 0;
        end
        b_hs     = bvalid && bready;
        pop_pend = fifo_rd_en;
        aw_pend  = awvalid && !awready;
        aw_prev  = {awvalid, awaddr, awlen};
        w_pend   = wvalid && !wready;
        w_prev   = {wvalid, wlast, wstrb, wdata};
    endtask

    task automatic drive_step();
        if (rst) begin
            bvalid    = 0;
            b_pending = 0;
            pop_pend  = 0;
            aw_hold   = 0;
            w_hold    = 0;
            b_wait    = 0;
        end else begin
            if (pop_pend) begin
                if (fq.size() > 0) fifo_rd_out = fq.pop_front();
                pops++;
                pop_pend = 0;
            end
            if (src.size() > 0 && $urandom_range(0, 99) < trickle)
                fq.push_back(src.pop_front());
            if (awvalid && aw_hold < stall_len) begin
                awready = 0;
                aw_hold++;
            end else awready = ($urandom_range(0, 99) < ready_pct);
            if (wvalid && w_hold < stall_len) begin
                wready = 0;
                w_hold++;
            end else wready = ($urandom_range(0, 99) < ready_pct);
            if (b_hs) begin
                bvalid = 0;
                b_pending--;
                b_hs = 0;
            end
            if (!bvalid && b_pending > 0) begin
                if (b_wait > 0) b_wait--;
                else begin
                    bvalid = 1;
                    bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
                    b_idx++;
                    b_wait = $urandom_range(0, 6);
                end
            end
        end
        fifo_rd_count = 9'(fq.size());
    endtask

    task automatic agent();
        forever begin
            @(negedge clk);
            monitor_step();
            @(posedge clk);
            #1;
            drive_step();
        end
    endtask

    // Reference: walk the job in page-limited bursts of up to 16 beats, pairing words lo-first.
    task automatic prep_job(input logic [31:0] b, input int len, input int ebur, input int stall,
                            input int rpct, input int trick, input bit seq, output int exp_pops);
        logic [31:0] words[$];
        logic [31:0] a, lo, hi;
        logic [7:0]  strb;
        int beats, wi, blen, nb;
        words.delete();
        for (int i = 0; i < len; i++) words.push_back(seq ? 32'(i + 1) : $urandom());
        fq.delete();
        src.delete();
        foreach (words[i]) begin
            if (trick == 0) fq.push_back(words[i]);
            else            src.push_back(words[i]);
        end
        exp_aw.delete();
        exp_w.delete();
        a = {b[31:3], 3'b000};
        beats = (len + 1) / 2;
        wi = 0;
        nb = 0;
        while (beats > 0 && (ebur < 0 || nb <= ebur)) begin
            blen = (beats > 16) ? 16 : beats;
            if ((4096 - int'(a[11:0])) / 8 < blen) blen = (4096 - int'(a[11:0])) / 8;
            exp_aw.push_back({a, 4'(blen - 1)});
            for (int k = 0; k < blen; k++) begin
                lo = words[wi];
                wi++;
                if (wi < len) begin
                    hi = words[wi];
                    wi++;
                    strb = 8'hFF;
                end else begin
                    hi = 32'd0;
                    strb = 8'h0F;
                end
                exp_w.push_back({k == blen - 1, strb, hi, lo});
            end
            a += 32'(8 * blen);
            beats -= blen;
            nb++;
        end
        n_exp_aw = exp_aw.size();
        n_exp_w  = exp_w.size();
        exp_pops = wi;
        stall_len = stall;
        ready_pct = rpct;
        trickle   = trick;
        err_burst = ebur;
        b_idx = 0;
        pops = 0;
        aw_cnt = 0;
        w_cnt = 0;
        wl_cnt = 0;
        dma_base_addr = b;
        dma_word_len  = 16'(len);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 dma_start = 1;
        @(posedge clk);
        #1 dma_start = 0;
    endtask

    task automatic run_job(input logic [31:0] b, input int len, input int ebur, input int stall,
                           input int rpct, input int trick, input bit seq);
        int exp_pops, lat;
        bit got;
        prep_job(b, len, ebur, stall, rpct, trick, seq, exp_pops);
        pulse_start();
        got = 0;
        lat = -1;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            if (c == 0 && len != 0) check("busy_run", 128'(dma_busy), 128'd1);
            if (dma_done) begin
                got = 1;
                lat = c;
            end
        end
        check("done_seen", 128'(got), 128'd1);
        if (len == 0) check("len0_latency", 128'(lat), 128'd0);
        check("err_flag", 128'(dma_err), 128'(ebur >= 0));
        @(negedge clk);
        check("done_pulse", 128'({dma_done, dma_busy}), 128'd0);
        repeat (20) @(negedge clk);
        check("aw_count", 128'(aw_cnt), 128'(n_exp_aw));
        check("w_count", 128'(w_cnt), 128'(n_exp_w));
        check("pops", 128'(pops), 128'(exp_pops));
    endtask

    initial begin
        logic [31:0] rb;
        int dummy;
        bit seen;
        rst = 1;
        dma_enable = 1;
        dma_start = 0;
        dma_base_addr = 0;
        dma_word_len = 0;
        fifo_rd_out = 0;
        fifo_rd_count = 0;
        awready = 0;
        wready = 0;
        bvalid = 0;
        bresp = 0;
        trickle = 0;
        ready_pct = 100;
        stall_len = 0;
        err_burst = -1;
        fork
            agent();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'({dma_busy, dma_done, dma_err, fifo_rd_en, awvalid, awaddr, awlen,
                                     wvalid, wdata, wstrb, wlast, bready, dbg_state}), 128'd0);
        check("awsize", 128'(awsize), 128'd3);
        check("awburst", 128'(awburst), 128'd1);
        check("awcache", 128'(awcache), 128'd3);
        check("awid", 128'(awid), 128'd1);
        check("wid", 128'(wid), 128'd1);
        @(negedge clk);
        rst = 0;

        run_job(32'h1000_0000, 32, -1, 0, 100, 0, 0);
        run_job(32'h1000_0FE0, 16, -1, 0, 70, 0, 0);
        run_job(32'h1000_0200, 5, -1, 0, 80, 0, 1);
        run_job(32'h2000_0100, 20, -1, 10, 60, 0, 0);
        run_job(32'h1000_0FE0, 16, 0, 0, 80, 0, 0);
        run_job(32'h3000_0005, 7, -1, 0, 90, 0, 0);
        run_job(32'h3000_0000, 0, -1, 0, 100, 0, 0);

        prep_job(32'h4000_0000, 32, -1, 0, 100, 0, 0, dummy);
        pulse_start();
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (wvalid) seen = 1;
        end
        check("rst_wvalid_seen", 128'(seen), 128'd1);
        rst = 1;
        #1;
        check("rst_mid_data", 128'({dma_busy, dma_done, dma_err, fifo_rd_en, awvalid, awaddr, awlen,
                                    wvalid, wdata, wstrb, wlast, bready, dbg_state}), 128'd0);
        repeat (3) @(negedge clk);
        rst = 0;

        for (int j = 0; j < 8; j++) begin
            rb = $urandom();
            run_job(rb, $urandom_range(1, 80), -1, 0, $urandom_range(30, 100), 40, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
